// File: rtl/fp_cvt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_cvt_pkg
// Brief    : Shared constants and rounding helper for the FP conversion units.
// Revision : 1.0
// ============================================================================
package fp_cvt_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int DP_EXP_W = 11;
    localparam int DP_MAN_W = 52;
    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;

    localparam int DP_BIAS = 1023;
    localparam int SP_BIAS = 127;

    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

    // Magnitude increment decision; unknown modes fall back to RNE.
    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic sticky);
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & (guard | sticky);
            RM_RUP:  round_up = ~sign & (guard | sticky);
            RM_RMM:  round_up = guard;
            default: round_up = guard & (sticky | lsb);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc
// Brief    : Parameterised leading-zero counter with all-zero flag.
// Revision : 1.0
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]         i_data,
    output logic [$clog2(WIDTH)-1:0] o_count,
    output logic                     o_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule
`default_nettype wire

// File: rtl/fp_cvt_i2f_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_cvt_i2f_pipe
// Brief    : 3-stage integer-to-float converter (fcvt.{s,d}.{w,wu,l,lu}).
//            Optional FP_CVT_FLUSH_EN adds a pipeline flush input.
// Revision : 1.0
// ============================================================================
module fp_cvt_i2f_pipe
    import fp_cvt_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FP_CVT_FLUSH_EN
    input  logic             i_flush,
`endif
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [XLEN-1:0]  i_int_in,
    input  logic             i_is_signed,
    input  logic             i_src_64,
    input  logic             i_dst_dp,
    input  logic [2:0]       i_rm,
    input  logic [TAG_W-1:0] i_tag_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [63:0]      o_result,
    output logic [4:0]       o_fflags,
    output logic [TAG_W-1:0] o_tag_out
);
    logic w_stall, w_flush;
    logic [63:0] w_ext, w_sext, w_mag;
    logic w_src64, w_sign;

    logic             r1_valid, r1_sign, r1_dp;
    logic [63:0]      r1_mag;
    logic [2:0]       r1_rm;
    logic [TAG_W-1:0] r1_tag;

    logic             r2_valid, r2_sign, r2_dp, r2_zero;
    logic [63:0]      r2_norm;
    logic [10:0]      r2_exp;
    logic [2:0]       r2_rm;
    logic [TAG_W-1:0] r2_tag;

    logic             r3_valid;
    logic [63:0]      r3_result;
    logic [4:0]       r3_fflags;
    logic [TAG_W-1:0] r3_tag;

`ifdef FP_CVT_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_stall     = r3_valid & ~i_out_ready;
    assign o_in_ready  = ~w_stall & ~w_flush;
    assign o_out_valid = r3_valid;
    assign o_result    = r3_result;
    assign o_fflags    = r3_fflags;
    assign o_tag_out   = r3_tag;

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_ext   = i_int_in;
            assign w_src64 = i_src_64;
        end else begin : g_xlen32
            logic w_unused_src;
            assign w_ext        = {32'd0, i_int_in};
            assign w_src64      = 1'b0;
            assign w_unused_src = i_src_64;
        end
    endgenerate

    // S1: sign-extend a 32-bit source so one 64-bit negate covers both widths.
    assign w_sext = w_src64 ? w_ext : {{32{i_is_signed & w_ext[31]}}, w_ext[31:0]};
    assign w_sign = i_is_signed & w_sext[63];
    assign w_mag  = w_sign ? (~w_sext + 64'd1) : w_sext;

    // S2: normalise so the leading one lands on bit 63.
    logic [5:0]  w_lzc;
    logic        w_zero;
    logic [63:0] w_norm;
    logic [10:0] w_bias, w_exp;

    fp_lzc #(.WIDTH(64)) u_lzc (
        .i_data  (r1_mag),
        .o_count (w_lzc),
        .o_zero  (w_zero)
    );

    assign w_norm = r1_mag << w_lzc;
    assign w_bias = r1_dp ? 11'(DP_BIAS) : 11'(SP_BIAS);
    assign w_exp  = w_bias + 11'd63 - {5'd0, w_lzc};

    // S3: keep 53 (double) or 24 (single) bits; a carry-out means 2.0 -> exp+1.
    logic [53:0] w_keep, w_sum;
    logic        w_guard, w_sticky, w_up, w_carry, w_nx;
    logic [10:0] w_exp_f;
    logic [63:0] w_res;
    logic [4:0]  w_flags;
    logic        w_unused_hidden;

    assign w_keep   = r2_dp ? {1'b0, r2_norm[63:11]} : {30'd0, r2_norm[63:40]};
    assign w_guard  = r2_dp ? r2_norm[10] : r2_norm[39];
    assign w_sticky = r2_dp ? |r2_norm[9:0] : |r2_norm[38:0];
    assign w_up     = round_up(r2_rm, r2_sign, w_keep[0], w_guard, w_sticky);
    assign w_sum    = w_keep + {53'd0, w_up};
    assign w_carry  = r2_dp ? w_sum[53] : w_sum[24];
    assign w_exp_f  = r2_zero ? 11'd0 : (r2_exp + {10'd0, w_carry});
    assign w_nx     = w_guard | w_sticky;
    assign w_unused_hidden = w_sum[52];

    assign w_res = r2_dp ? {r2_sign, w_exp_f[DP_EXP_W-1:0], w_sum[DP_MAN_W-1:0]}
                         : {NAN_BOX, r2_sign, w_exp_f[SP_EXP_W-1:0], w_sum[SP_MAN_W-1:0]};

    always_comb begin
        w_flags           = '0;
        w_flags[FFLAG_NX] = w_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0; r1_sign <= 1'b0; r1_dp <= 1'b0;
            r1_mag    <= '0;   r1_rm   <= '0;   r1_tag <= '0;
            r2_valid  <= 1'b0; r2_sign <= 1'b0; r2_dp <= 1'b0; r2_zero <= 1'b0;
            r2_norm   <= '0;   r2_exp  <= '0;   r2_rm <= '0;   r2_tag <= '0;
            r3_valid  <= 1'b0;
            r3_result <= '0;   r3_fflags <= '0; r3_tag <= '0;
        end else begin
            if (w_flush) begin
                r1_valid <= 1'b0;
                r2_valid <= 1'b0;
                r3_valid <= 1'b0;
            end else if (!w_stall) begin
                r1_valid <= i_in_valid;
                r2_valid <= r1_valid;
                r3_valid <= r2_valid;
            end
            if (!w_stall) begin
                r1_sign   <= w_sign;
                r1_mag    <= w_mag;
                r1_dp     <= i_dst_dp;
                r1_rm     <= i_rm;
                r1_tag    <= i_tag_in;
                r2_sign   <= r1_sign;
                r2_norm   <= w_norm;
                r2_exp    <= w_exp;
                r2_zero   <= w_zero;
                r2_dp     <= r1_dp;
                r2_rm     <= r1_rm;
                r2_tag    <= r1_tag;
                r3_result <= w_res;
                r3_fflags <= w_flags;
                r3_tag    <= r2_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_cvt_i2f_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_cvt_i2f_pipe
// Brief    : Scoreboard bench for fp_cvt_i2f_pipe with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_fp_cvt_i2f_pipe;
    import fp_cvt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush = 1'b0;
    logic        in_valid, in_ready_unused, is_signed, src_64, dst_dp, out_ready;
    logic [63:0] int_in;
    logic [2:0]  rm;
    logic [4:0]  tag_in;
    logic        o_in_ready, o_out_valid;
    logic [63:0] o_result;
    logic [4:0]  o_fflags, o_tag_out;

    always #5 clk = ~clk;

    fp_cvt_i2f_pipe #(.XLEN(64), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FP_CVT_FLUSH_EN
        .i_flush     (flush),
`endif
        .i_in_valid  (in_valid),
        .o_in_ready  (o_in_ready),
        .i_int_in    (int_in),
        .i_is_signed (is_signed),
        .i_src_64    (src_64),
        .i_dst_dp    (dst_dp),
        .i_rm        (rm),
        .i_tag_in    (tag_in),
        .o_out_valid (o_out_valid),
        .i_out_ready (out_ready),
        .o_result    (o_result),
        .o_fflags    (o_fflags),
        .o_tag_out   (o_tag_out)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0, bad = 0, cyc = 0, pushed = 0, popped = 0;
    logic [73:0] snap;
    bit prev_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Monitor: everything seen with valid && ready at a negedge is taken at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_out_valid && !out_ready) begin
                if (prev_stall) begin
                    total++;
                    if ({o_result, o_fflags, o_tag_out} !== snap) begin
                        bad++;
                        $display("FAIL hold got=%h want=%h", {o_result, o_fflags, o_tag_out}, snap);
                    end
                end
                snap = {o_result, o_fflags, o_tag_out};
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (o_out_valid && out_ready && !flush) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out tag=%0d got=%h want=none", o_tag_out, o_result);
                end else begin
                    mon_e = sb.pop_front();
                    popped++;
                    if (o_result !== mon_e.res || o_fflags !== mon_e.fl || o_tag_out !== mon_e.tag) begin
                        bad++;
                        $display("FAIL result tag=%0d got=%h/%b/%0d want=%h/%b/%0d", mon_e.tag,
                                 o_result, o_fflags, o_tag_out, mon_e.res, mon_e.fl, mon_e.tag);
                    end
                    if (mon_e.lat) begin
                        total++;
                        if (cyc - mon_e.acc != 3) begin
                            bad++;
                            $display("FAIL latency tag=%0d got=%0d want=3", mon_e.tag, cyc - mon_e.acc);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] v, input bit sg, input bit s64, input bit dp,
                        input logic [2:0] r, input logic [4:0] t, input logic [63:0] er,
                        input bit nx, input bit lat, input bit push);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        int_in = v; is_signed = sg; src_64 = s64; dst_dp = dp; rm = r; tag_in = t;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (o_in_ready) begin
                if (push) begin
                    e.res = er; e.fl = nx ? 5'b00001 : 5'b00000; e.tag = t;
                    e.acc = cyc; e.lat = lat;
                    sb.push_back(e);
                    pushed++;
                end
                done = 1'b1;
            end else if (++n > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout tag=%0d got=stuck want=accepted", t);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d want=0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [63:0] v, input bit sg, input bit s64, input bit dp,
                       input logic [2:0] r, input logic [4:0] t, input logic [63:0] er, input bit nx);
        send(v, sg, s64, dp, r, t, er, nx, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ready_unused = 1'b0;
        int_in = '0; is_signed = 1'b0; src_64 = 1'b0; dst_dp = 1'b0; rm = '0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
        chk("rst_result", o_result, 64'd0);
        chk("rst_fflags", {59'd0, o_fflags}, 64'd0);
        chk("rst_tag", {59'd0, o_tag_out}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        one(64'hFFFF_FFFF, 1, 0, 1, RM_RNE, 5'd1, 64'hBFF0000000000000, 0);
        one(64'h8000_0000, 1, 0, 1, RM_RNE, 5'd2, 64'hC1E0000000000000, 0);
        one(64'hFFFF_FFFF, 0, 0, 1, RM_RNE, 5'd3, 64'h41EFFFFFFFE00000, 0);
        one(64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 1, RM_RNE, 5'd4, 64'h43E0000000000000, 1);
        one(64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 1, RM_RTZ, 5'd5, 64'h43DFFFFFFFFFFFFF, 1);
        one(64'h0100_0001, 1, 0, 0, RM_RNE, 5'd6, 64'hFFFFFFFF4B800000, 1);
        one(64'h0100_0001, 1, 0, 0, RM_RUP, 5'd7, 64'hFFFFFFFF4B800001, 1);
        one(64'h0, 1, 0, 1, RM_RDN, 5'd8, 64'h0000000000000000, 0);
        one(64'h8000_0000_0000_0000, 1, 1, 1, RM_RNE, 5'd9, 64'hC3E0000000000000, 0);
        one(64'h0, 1, 1, 0, RM_RDN, 5'd14, 64'hFFFFFFFF00000000, 0);
        one(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, RM_RDN, 5'd15, 64'hFFFFFFFFBF800000, 0);
        one(64'h0100_0003, 0, 0, 0, 3'd7, 5'd16, 64'hFFFFFFFF4B800002, 1);
        one(64'h0100_0001, 0, 0, 0, RM_RTZ, 5'd17, 64'hFFFFFFFF4B800000, 1);

        // Backpressure: four back-to-back ops against a consumer that stalls 5 cycles.
        out_ready = 1'b0;
        fork
            begin
                send(64'h0100_0001, 0, 0, 0, RM_RMM, 5'd10, 64'hFFFFFFFF4B800001, 1, 0, 1);
                send(64'hFEFF_FFFF, 1, 0, 0, RM_RDN, 5'd11, 64'hFFFFFFFFCB800001, 1, 0, 1);
                send(64'hDEAD_BEEF_0000_0003, 1, 0, 1, RM_RNE, 5'd12, 64'h4008000000000000, 0, 0, 1);
                send(64'h8000_0000_0000_0000, 1, 1, 1, RM_RUP, 5'd13, 64'hC3E0000000000000, 0, 0, 1);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready", {63'd0, o_in_ready}, 64'd0);
                chk("bp_out_valid", {63'd0, o_out_valid}, 64'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

`ifdef FP_CVT_FLUSH_EN
        send(64'd5, 0, 0, 1, RM_RNE, 5'd20, 64'd0, 0, 0, 0);
        send(64'd6, 0, 0, 1, RM_RNE, 5'd21, 64'd0, 0, 0, 0);
        send(64'd7, 0, 0, 1, RM_RNE, 5'd22, 64'd0, 0, 0, 0);
        int_in = 64'd9; tag_in = 5'd23;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {63'd0, o_in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("flush_out_valid", {63'd0, o_out_valid}, 64'd0);
        one(64'd1, 0, 0, 1, RM_RNE, 5'd24, 64'h3FF0000000000000, 0);
`endif

        drain();
        chk("all_delivered", 64'(popped), 64'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_cvt_i2f_pipe.md
Name: fp_cvt_i2f_pipe

Overview:
Pipelined integer-to-floating-point converter for the D/F-extension ALU. It covers fcvt.{s,d}.{w,wu,l,lu} and replaces the single-mode combinational int32-to-double path.
- Integer width, signedness, destination precision and rounding mode are all selectable per operation.
- Rounding and the NX flag follow IEEE 754.
- Single-precision results are NaN-boxed into the 64-bit FP register format.
- 3-stage pipeline with valid/ready handshakes on both sides; sits between the issue stage and FP writeback.

Parameters:
XLEN, 64, maximum integer source width; legal values 32 or 64. With 32, src_64 is ignored.
TAG_W, 5, width of the opaque tag carried alongside each operation (destination register).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  converter accepts when in_valid && in_ready
int_in  in  XLEN  integer source operand
is_signed  in  1  1 = two's complement, 0 = unsigned
src_64  in  1  1 = use all 64 bits; 0 = use int_in[31:0] only, upper bits ignored
dst_dp  in  1  1 = double result, 0 = single result
rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 are treated as RNE
tag_in  in  TAG_W  tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts when out_valid && out_ready
result  out  64  IEEE 754 result; single results have bits [63:32] forced to all ones
fflags  out  5  {NV,DZ,OF,UF,NX}; only NX can be set
tag_out  out  TAG_W  tag of the result

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, result = 0, fflags = 0, tag_out = 0.
- Pipeline:
  - S1: register operands; select 32- or 64-bit source; sign = is_signed && source MSB; magnitude = abs value, taken as unsigned 64-bit so 0x8000_0000_0000_0000 is handled correctly.
  - S2: leading-zero count and left-normalise so the leading 1 sits at bit 63; exponent = bias + 63 - lzc, with bias 1023 (double) or 127 (single).
  - S3: round, pack, flags; S3 registers drive the outputs.
- Latency: exactly 3 cycles from acceptance to out_valid when there is no backpressure. Throughput: 1 operation per cycle.
- Stall: stall = out_valid && !out_ready. While stalled, all stages hold and in_ready = 0. Otherwise in_ready = 1. Bubbles do not collapse; this is a simple global stall.
- Ordering: results leave in acceptance order. No drop or duplication under any pattern of out_ready.
- Rounding:
  - Guard bit = first dropped bit; sticky = OR of all remaining dropped bits.
  - Double keeps 53 significant bits; single keeps 24.
  - RNE: round up if guard && (sticky || lsb). RMM: round up if guard. RTZ: never round up.
  - RDN: round up in magnitude if negative && (guard || sticky). RUP: round up in magnitude if positive && (guard || sticky).
  - If the rounded significand carries out, it becomes 1.0 and the exponent increments.
- NX = guard || sticky. NV, DZ, OF and UF are always 0; overflow is impossible for these widths.
- Zero input gives +0.0 in every rounding mode, including RDN, with NX = 0.
- Exact cases: any 32-bit source to double is always exact, NX = 0.
- Output hold: result, fflags and tag_out must not change while out_valid && !out_ready.

Optional Feature:
Macro FP_CVT_FLUSH_EN.
- Defined: adds input port flush (1 bit). On a cycle with flush = 1, all stage valids and out_valid clear at the next edge, and any operation offered that same cycle is not accepted (in_ready = 0 during flush). Flush wins over a simultaneous out_ready handshake: that result is discarded.
- Undefined: no flush port; nothing is discarded except through reset.

Decomposition:
Package fp_cvt_pkg holds:
- rounding-mode localparams (RM_RNE..RM_RMM)
- field widths: DP_EXP_W = 11, DP_MAN_W = 52, SP_EXP_W = 8, SP_MAN_W = 23
- biases 1023 and 127
- fflags bit indices
- the NaN-box constant 32'hFFFF_FFFF

One sub-module: fp_lzc, a parameterised leading-zero counter (WIDTH = 64, output clog2 width, plus an all-zero flag), reused later by fcvt.w.d and normalisation logic.

Test Plan:
- int_in = 0xFFFF_FFFF, signed, src_64 = 0, double, RNE -> result 0xBFF0000000000000, NX = 0, out_valid exactly 3 cycles after acceptance.
- int_in = 0x8000_0000 signed, and separately 0xFFFF_FFFF unsigned, both to double -> results 0xC1E0000000000000 and 0x41EFFFFFFFE00000, NX = 0.
- int_in = 0x7FFF_FFFF_FFFF_FFFF, signed, src_64 = 1, double: RNE -> 0x43E0000000000000, NX = 1; RTZ -> 0x43DFFFFFFFFFFFFF, NX = 1.
- int_in = 0x0100_0001, single: RNE -> 0xFFFFFFFF4B800000 (tie to even), NX = 1; RUP -> 0xFFFFFFFF4B800001, NX = 1.
- int_in = 0, signed, RDN, double -> 0x0000000000000000, NX = 0.
- Backpressure: 4 back-to-back operations with out_ready low for 5 cycles -> in_ready drops to 0, outputs held stable, all 4 results delivered in order with the correct tags. With FP_CVT_FLUSH_EN defined, a flush pulse mid-stream -> no results for the in-flight tags.
